// File: rtl/hs32_trace_pkg.sv
// rtl/hs32_trace_pkg.sv - shared register map, status bits and trace entry layout
package hs32_trace_pkg;

    typedef enum logic [1:0] {
        TRC_CTRL = 2'd0,
        TRC_META = 2'd1,
        TRC_DATA = 2'd2,
        TRC_STEP = 2'd3
    } trc_reg_e;

    localparam int ST_EMPTY = 16;
    localparam int ST_FULL  = 17;
    localparam int ST_OVF   = 18;
    localparam int ST_EN    = 19;

    // Trace entry layout, LSB first: din[31:0], wadr[35:32], bank[36], step stamp above.
    localparam int ENT_DIN_LSB  = 0;
    localparam int ENT_WADR_LSB = 32;
    localparam int ENT_BANK_BIT = 36;
    localparam int ENT_STEP_LSB = 37;

    function automatic int entry_w(input int step_w);
        return step_w + 37;
    endfunction

endpackage

// File: rtl/hs32_regwr_trace_if.sv
// rtl/hs32_regwr_trace_if.sv - Wishbone classic slave bundle for the trace unit
interface hs32_regwr_trace_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/hs32_trace_fifo.sv
// rtl/hs32_trace_fifo.sv - first-word-fall-through synchronous FIFO with flush
module hs32_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 53
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rptr_q];

    // Pop on empty is ignored; a pop on full frees the slot a same-cycle push needs; flush wins.
    always_comb begin
        do_pop  = pop & ~empty & ~flush;
        do_push = push & (~full | do_pop) & ~flush;
        wptr_d  = flush ? '0 : wptr_q + AW'(do_push);
        rptr_d  = flush ? '0 : rptr_q + AW'(do_pop);
        count_d = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem_q[wptr_q] <= din;
    end
endmodule

// File: rtl/hs32_regwr_trace.sv
// rtl/hs32_regwr_trace.sv - register-file write trace FIFO behind a Wishbone slave
module hs32_regwr_trace
    import hs32_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int STEP_W = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 trig_we,
    input  logic                 trig_bank,
    input  logic [3:0]           trig_wadr,
    input  logic [31:0]          trig_din,
    hs32_regwr_trace_if.slave    wb,
    output logic                 irq_o
);
    localparam int ENTRY_W = entry_w(STEP_W);
    localparam int CW      = $clog2(DEPTH) + 1;

    logic [31:0]        step_q, step_d;
    logic               ovf_q, ovf_d;
    logic               en_q, en_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic               irq_q, irq_d;

    logic               req, rd, ctrl_wr, clear, push, fifo_pop;
    trc_reg_e           reg_sel;
    logic [ENTRY_W-1:0] entry, head;
    logic [CW-1:0]      count;
    logic               full, empty;
    logic [31:0]        status, meta, rd_data;
    logic               unused_wb;

    assign unused_wb = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1], wb.wbs_dat_i[31:2]};

    hs32_trace_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .push     (push),
        .pop      (fifo_pop),
        .flush    (clear),
        .din      (entry),
        .dout     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Bus decode, read mux and next-state for counters and flags.
    always_comb begin
        req      = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q;
        reg_sel  = trc_reg_e'(wb.wbs_adr_i[3:2]);
        rd       = req & ~wb.wbs_we_i;
        ctrl_wr  = req & wb.wbs_we_i & (reg_sel == TRC_CTRL) & wb.wbs_sel_i[0];
        clear    = ctrl_wr & wb.wbs_dat_i[1];
        fifo_pop = rd & (reg_sel == TRC_DATA);
        push     = trig_we & en_q;
        entry    = {step_q[STEP_W-1:0], trig_bank, trig_wadr, trig_din};

        status            = '0;
        status[15:0]      = 16'(count);
        status[ST_EMPTY]  = empty;
        status[ST_FULL]   = full;
        status[ST_OVF]    = ovf_q;
        status[ST_EN]     = en_q;

        meta        = '0;
        if (!empty) begin
            meta[31:16] = 16'(head[ENT_STEP_LSB +: STEP_W]);
            meta[8]     = head[ENT_BANK_BIT];
            meta[3:0]   = head[ENT_WADR_LSB +: 4];
        end

        case (reg_sel)
            TRC_CTRL: rd_data = status;
            TRC_META: rd_data = meta;
            TRC_DATA: rd_data = empty ? 32'd0 : head[ENT_DIN_LSB +: 32];
            default:  rd_data = step_q;
        endcase

        ack_d = req;
        dat_d = rd ? rd_data : 32'd0;
        // A dropped push (full, no pop) still advances step so the gap shows up in the stamps.
        ovf_d  = clear ? 1'b0 : (ovf_q | (push & full & ~fifo_pop));
        en_d   = ctrl_wr ? wb.wbs_dat_i[0] : en_q;
        step_d = clear ? 32'd0 : step_q + 32'(push);
        irq_d  = ~empty & en_q;
    end

    // Control/status registers and registered bus outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            step_q <= '0;
            ovf_q  <= 1'b0;
            en_q   <= 1'b1;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            step_q <= step_d;
            ovf_q  <= ovf_d;
            en_q   <= en_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
        end
    end

    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign irq_o        = irq_q;
endmodule

// File: tb/tb_hs32_regwr_trace.sv
// tb/tb_hs32_regwr_trace.sv - self-checking bench for hs32_regwr_trace
module tb_hs32_regwr_trace;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig_we = 1'b0;
    logic        trig_bank = 1'b0;
    logic [3:0]  trig_wadr = '0;
    logic [31:0] trig_din = '0;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    hs32_regwr_trace_if wb_if ();

    hs32_regwr_trace #(.DEPTH(DEPTH), .STEP_W(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .trig_we   (trig_we),
        .trig_bank (trig_bank),
        .trig_wadr (trig_wadr),
        .trig_din  (trig_din),
        .wb        (wb_if),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned step;
        bit          bank;
        bit [3:0]    wadr;
        bit [31:0]   din;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_step;
    bit          m_ovf;
    bit          m_en;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_step = 0;
        m_ovf  = 0;
        m_en   = 1;
    endfunction

    // Reads see the state before this cycle's capture; the capture then lands, then CTRL takes effect.
    function automatic bit [31:0] model_step(input bit is_wb, input bit we, input int rsel,
                                             input bit [31:0] wdat, input bit [3:0] sel,
                                             input bit trig, input bit bank, input bit [3:0] wadr,
                                             input bit [31:0] din);
        bit [31:0] r = 0;
        ent_t      e;
        if (is_wb && !we) begin
            case (rsel)
                0: r = mq.size() | ((mq.size() == 0) << 16) | ((mq.size() == DEPTH) << 17)
                       | (m_ovf << 18) | (m_en << 19);
                1: if (mq.size() > 0) r = ((mq[0].step % 65536) << 16) | (mq[0].bank << 8) | mq[0].wadr;
                2: if (mq.size() > 0) begin r = mq[0].din; void'(mq.pop_front()); end
                default: r = m_step;
            endcase
        end
        if (trig && m_en) begin
            e.step = m_step; e.bank = bank; e.wadr = wadr; e.din = din;
            if (mq.size() < DEPTH) mq.push_back(e);
            else m_ovf = 1;
            m_step = m_step + 1;
        end
        if (is_wb && we && rsel == 0 && sel[0]) begin
            m_en = wdat[0];
            if (wdat[1]) begin mq.delete(); m_step = 0; m_ovf = 0; end
        end
        return r;
    endfunction

    task automatic wb_access(input bit we, input int rsel, input bit [31:0] wdat, input bit [3:0] sel,
                             input bit trig, input bit bank, input bit [3:0] wadr, input bit [31:0] din,
                             output bit [31:0] rdat, output bit acked);
        @(negedge clk);
        wb_if.wbs_cyc_i = 1; wb_if.wbs_stb_i = 1; wb_if.wbs_we_i = we;
        wb_if.wbs_sel_i = sel; wb_if.wbs_adr_i = 32'(rsel) << 2; wb_if.wbs_dat_i = wdat;
        trig_we = trig; trig_bank = bank; trig_wadr = wadr; trig_din = din;
        acked = 0; rdat = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            trig_we = 0;
            if (wb_if.wbs_ack_o) begin acked = 1; rdat = wb_if.wbs_dat_o; break; end
        end
        @(negedge clk);
        wb_if.wbs_cyc_i = 0; wb_if.wbs_stb_i = 0; wb_if.wbs_we_i = 0;
    endtask

    task automatic xact(input string name, input bit we, input int rsel, input bit [31:0] wdat,
                        input bit [3:0] sel, input bit trig, input bit bank, input bit [3:0] wadr,
                        input bit [31:0] din);
        bit [31:0] exp, got;
        bit        acked;
        exp = model_step(1, we, rsel, wdat, sel, trig, bank, wadr, din);
        wb_access(we, rsel, wdat, sel, trig, bank, wadr, din, got, acked);
        check({name, "_ack"}, 32'(acked), 32'd1);
        if (!we) check(name, got, exp);
    endtask

    task automatic push_only(input bit bank, input bit [3:0] wadr, input bit [31:0] din);
        void'(model_step(0, 0, 0, 0, 0, 1, bank, wadr, din));
        @(negedge clk);
        trig_we = 1; trig_bank = bank; trig_wadr = wadr; trig_din = din;
        @(negedge clk);
        trig_we = 0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (mq.size() > 0 && guard < 2 * DEPTH) begin
            xact({name, "_meta"}, 0, 1, 0, 4'hF, 0, 0, 0, 0);
            xact({name, "_data"}, 0, 2, 0, 4'hF, 0, 0, 0, 0);
            guard++;
        end
    endtask

    typedef struct {
        string     name;
        int        op;     // 0 push {bank=data[8], wadr=data[3:0], din=0xF}, 1 read, 2 irq level
        int        rsel;
        bit [31:0] data;
        bit [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit [31:0] got;
        bit        acked;

        wb_if.wbs_cyc_i = 0; wb_if.wbs_stb_i = 0; wb_if.wbs_we_i = 0;
        wb_if.wbs_sel_i = 0; wb_if.wbs_adr_i = 0; wb_if.wbs_dat_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0;

        vecs = '{
            '{"rst_status", 1, 0, 0, 32'h0009_0000},
            '{"rst_irq",    2, 0, 0, 32'h0},
            '{"push_s0",    0, 0, 32'h000, 0},
            '{"push_u1",    0, 0, 32'h101, 0},
            '{"push_s1",    0, 0, 32'h001, 0},
            '{"cnt3",       1, 0, 0, 32'h0008_0003},
            '{"irq_on",     2, 0, 0, 32'h1},
            '{"meta0",      1, 1, 0, 32'h0000_0000},
            '{"data0",      1, 2, 0, 32'h0000_000F},
            '{"meta1",      1, 1, 0, 32'h0001_0101},
            '{"data1",      1, 2, 0, 32'h0000_000F},
            '{"meta2",      1, 1, 0, 32'h0002_0001},
            '{"data2",      1, 2, 0, 32'h0000_000F},
            '{"empty_st",   1, 0, 0, 32'h0009_0000},
            '{"irq_off",    2, 0, 0, 32'h0},
            '{"step3",      1, 3, 0, 32'd3},
            '{"data_empty", 1, 2, 0, 32'h0},
            '{"meta_empty", 1, 1, 0, 32'h0},
            '{"still_empty",1, 0, 0, 32'h0009_0000}
        };
        foreach (vecs[i]) begin
            case (vecs[i].op)
                0: push_only(vecs[i].data[8], vecs[i].data[3:0], 32'hF);
                1: begin
                    void'(model_step(1, 0, vecs[i].rsel, 0, 4'hF, 0, 0, 0, 0));
                    wb_access(0, vecs[i].rsel, 0, 4'hF, 0, 0, 0, 0, got, acked);
                    check({vecs[i].name, "_ack"}, 32'(acked), 32'd1);
                    check(vecs[i].name, got, vecs[i].exp);
                end
                default: check(vecs[i].name, 32'(irq), vecs[i].exp);
            endcase
        end

        // Overflow: clear (keeping enable), then 18 pushes into a 16-deep FIFO.
        xact("clr", 1, 0, 32'h3, 4'h1, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) push_only(i[0], 4'(i), 32'h100 + 32'(i));
        wb_access(0, 0, 0, 4'hF, 0, 0, 0, 0, got, acked);
        check("full_status", got, 32'h000E_0010);
        wb_access(0, 3, 0, 4'hF, 0, 0, 0, 0, got, acked);
        check("step18", got, 32'd18);

        // Pop and push together while full: occupancy holds at 16.
        xact("full_popush", 0, 2, 0, 4'hF, 1, 1, 4'h7, 32'hCAFE_F00D);
        wb_access(0, 0, 0, 4'hF, 0, 0, 0, 0, got, acked);
        check("full_hold", got, 32'h000E_0010);
        drain("drain1");
        xact("drained", 0, 0, 0, 4'hF, 0, 0, 0, 0);

        // CTRL write without sel[0] must not clear.
        xact("nosel_wr", 1, 0, 32'h2, 4'hE, 0, 0, 0, 0);
        xact("nosel_step", 0, 3, 0, 4'hF, 0, 0, 0, 0);

        // Clear beats a same-cycle capture.
        push_only(0, 4'h2, 32'h55);
        push_only(1, 4'h3, 32'h66);
        xact("clr_push", 1, 0, 32'h3, 4'h1, 1, 1, 4'h9, 32'h77);
        wb_access(0, 0, 0, 4'hF, 0, 0, 0, 0, got, acked);
        check("clr_status", got, 32'h0009_0000);
        wb_access(0, 3, 0, 4'hF, 0, 0, 0, 0, got, acked);
        check("clr_step", got, 32'd0);

        // Disabled: captures ignored, step frozen.
        push_only(0, 4'h1, 32'h11);
        xact("dis", 1, 0, 32'h0, 4'h1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) push_only(1, 4'(i), 32'(i));
        wb_access(0, 0, 0, 4'hF, 0, 0, 0, 0, got, acked);
        check("dis_status", got, 32'h0000_0001);
        wb_access(0, 3, 0, 4'hF, 0, 0, 0, 0, got, acked);
        check("dis_step", got, 32'd1);
        check("dis_irq", 32'(irq), 32'd0);
        xact("ena", 1, 0, 32'h1, 4'h1, 0, 0, 0, 0);
        drain("drain2");

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            int          r   = int'($urandom_range(0, 9));
            bit          tr  = ($urandom_range(0, 9) < 6);
            bit          bk  = 1'($urandom_range(0, 1));
            bit [3:0]    wa  = 4'($urandom_range(0, 15));
            bit [31:0]   dn  = $urandom;
            case (r)
                0, 1:    if (tr) push_only(bk, wa, dn);
                2:       xact("rnd_status", 0, 0, 0, 4'hF, tr, bk, wa, dn);
                3:       xact("rnd_meta", 0, 1, 0, 4'hF, tr, bk, wa, dn);
                4, 5, 6: xact("rnd_data", 0, 2, 0, 4'hF, tr, bk, wa, dn);
                7:       xact("rnd_step", 0, 3, 0, 4'hF, tr, bk, wa, dn);
                8:       xact("rnd_ctrl", 1, 0, ($urandom_range(0, 15) == 0) ? 32'h3 : 32'h1,
                              4'h1, tr, bk, wa, dn);
                default: xact("rnd_ign", 1, int'($urandom_range(1, 3)), $urandom, 4'hF, tr, bk, wa, dn);
            endcase
        end
        drain("drain3");

        // Reset during a pending read: no ack, everything back to reset values.
        for (int i = 0; i < 3; i++) push_only(0, 4'(i), 32'h900 + 32'(i));
        @(negedge clk);
        wb_if.wbs_cyc_i = 1; wb_if.wbs_stb_i = 1; wb_if.wbs_we_i = 0;
        wb_if.wbs_adr_i = 32'h8; wb_if.wbs_sel_i = 4'hF;
        rst = 1;
        @(posedge clk); #1;
        check("rst_noack", 32'(wb_if.wbs_ack_o), 32'd0);
        @(negedge clk);
        rst = 0; wb_if.wbs_cyc_i = 0; wb_if.wbs_stb_i = 0;
        model_reset();
        @(posedge clk); #1;
        check("rst_irq2", 32'(irq), 32'd0);
        xact("rst_status2", 0, 0, 0, 4'hF, 0, 0, 0, 0);
        xact("rst_step2", 0, 3, 0, 4'hF, 0, 0, 0, 0);
        xact("rst_data2", 0, 2, 0, 4'hF, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hs32_regwr_trace.md
Name: hs32_regwr_trace

Overview:
- Capture unit placed beside the hs32 core's EXEC stage inside the user project.
- Records every register-file write (bank, address, data, step number) into a FIFO.
- Exposes the FIFO to the management SoC through a Wishbone slave.
- Lets firmware and benches check per-instruction writeback without hierarchical probes, so checks also work under gate-level simulation.

Parameters:
- DEPTH, 16, FIFO entries (power of two, 2..256)
- STEP_W, 16, width of per-entry step stamp

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- trig_we  in  1  regfile write strobe from EXEC (either bank)
- trig_bank  in  1  0 = supervisor regfile, 1 = user regfile
- trig_wadr  in  4  written register index
- trig_din  in  32  written data
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write
- wbs_sel_i  in  4  byte selects (only sel[0] is honoured on CTRL writes)
- wbs_adr_i  in  32  address; only [3:2] is decoded (base decode is external)
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- irq_o  out  1  high while FIFO non-empty and enabled

Behaviour:
- Reset (sync, wb_rst_i=1 at a clock edge):
  - FIFO emptied; step counter = 0; overflow = 0; enable = 1.
  - wbs_ack_o = 0, wbs_dat_o = 0, irq_o = 0.
- Capture:
  - On a clock edge with trig_we=1 and enable=1, form entry {step[STEP_W-1:0], bank, wadr, din}.
  - Push the entry; step_total (32-bit) increments by 1, wrapping at 2^32.
  - Entry appears in FIFO the following cycle (1-cycle write latency).
  - Push while full with no simultaneous pop: entry dropped, overflow set sticky, step still increments so gaps are visible.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: pop ignored, push succeeds.
  - trig_we with enable=0: ignored entirely, step unchanged.
- Register map (word offsets):
  - 0x0 CTRL/STATUS, read: [15:0] count, [16] empty, [17] full, [18] overflow, [19] enable.
  - 0x0 CTRL/STATUS, write with sel[0]: bit0 sets enable; bit1 = clear (flush FIFO, step = 0, overflow = 0). Clear beats a same-cycle push: the FIFO ends empty and step ends 0.
  - 0x4 HEAD_META, read: [31:16] step stamp, [8] bank, [3:0] wadr; other bits 0. Does not pop. Reads 0 when empty.
  - 0x8 HEAD_DATA, read: din of head entry, then pops it. Reads 0 and does not pop when empty.
  - 0xC STEP_TOTAL, read: step_total.
  - Writes to 0x4, 0x8 and 0xC are acked and ignored.
- Wishbone handshake:
  - Classic single-cycle. Request = cyc & stb & !ack.
  - wbs_ack_o rises exactly one cycle after the request and is held for one cycle only; back-to-back requests are acked every other cycle.
  - wbs_dat_o is registered alongside ack and is 0 when ack=0.
  - Pop on HEAD_DATA occurs at the edge where ack is raised.
  - Exactly one pop per transaction.
- irq_o is registered: !empty & enable, delayed one cycle.
- A reset asserted mid-transaction drops the pending ack; no pop occurs.

Decomposition:
- Package hs32_trace_pkg:
  - register offsets (TRC_CTRL=0, TRC_META=1, TRC_DATA=2, TRC_STEP=3)
  - STATUS bit positions
  - entry field widths/offsets (ENTRY_W = STEP_W+37)
- Sub-module hs32_trace_fifo:
  - synchronous FIFO with parameters DEPTH and WIDTH.
  - ports: push, pop, flush, din, dout (first-word-fall-through), count, full, empty.
  - same clock/reset.
- Top hs32_regwr_trace holds the step counter, overflow/enable flags and Wishbone decode.

Test Plan:
- Reset, then read 0x0 -> 0x0009_0000 (empty=1, enable=1, count=0); irq_o=0.
- Writes s0=0x000F, u1=0x000F, s1=0x000F:
  - read 0x0 -> count=3
  - 0x4 -> 0x0000_0000, 0x8 -> 0x0000_000F
  - 0x4 -> 0x0001_0101, 0x8 -> 0x0000_000F
  - 0x4 -> 0x0002_0001, 0x8 -> 0x0000_000F
  - then empty=1, irq_o=0.
- 18 pushes with DEPTH=16, no reads -> count=16, full=1, overflow=1, STEP_TOTAL=18; the last HEAD_META step reads 15.
- Full FIFO with a push in the same cycle as a HEAD_DATA pop -> count stays 16; the newest entry's step = previous step + 1.
- Write 0x0 = 0x2 (clear) concurrent with trig_we -> count=0, STEP_TOTAL=0, overflow=0.
- Write 0x0 = 0x0 (disable), pulse trig_we 5 times -> count and STEP_TOTAL unchanged.
- Read 0x8 when empty -> 0x0, no underflow.
- Assert wb_rst_i while a read is pending -> no ack, FIFO contents lost, state equals reset values.
